calc_alu_scheduler: RTL and testbench
=====================================

# calc_alu_scheduler

Shares the calculator's single combinational ALU between two requesters (keypad-entry path, index 0; sequenced-operation path, index 1). Arbitrates requests round-robin, translates the ARM-style 5-bit Funct into the 2-bit ALU control, drives the ALU from registered operands, and captures the result. Owns the architectural NZCV flag register and updates it under the S-bit rules. Returns one response per accepted request over a valid/ready handshake.

## Interface
- WIDTH, 32, operand/result width
- clk  in  1  clock, rising edge
- rst_n  in  1  reset; asynchronous, active-low
- req_valid  in  2  per-requester request valid; must hold until accepted
- req_ready  out  2  one-hot accept pulse
- req_funct  in  2x5  per-requester {cmd[3:0], S}
- req_cond  in  2x4  per-requester ARM condition code
- req_a, req_b  in  2xWIDTH  operands
- alu_a, alu_b  out  WIDTH  registered ALU operands
- alu_ctrl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
- alu_result  in  WIDTH  combinational ALU result
- alu_flags  in  4  ALU NZCV for current operands
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accepted
- rsp_id  out  1  requester index
- rsp_result  out  WIDTH  captured result
- rsp_wb  out  1  result is register-writeable (0 for CMP)
- rsp_err  out  1  unsupported cmd
- rsp_skip  out  1  condition failed, no operation
- flags  out  4  architectural NZCV

## Operation
- Cmd decode: 0100 ADD→00; 0010 SUB→01; 1010 CMP→01, rsp_wb=0; 0000 AND→10; 1100 ORR→11; others → rsp_err=1, no ALU use, no flag update.
- FlagW: S=1 on ADD/SUB/CMP writes all NZCV; S=1 on AND/ORR writes N,Z only (C,V keep); S=0 writes nothing.
- FSM states IDLE, EXEC, RESP.
- IDLE: if any req_valid, grant per round-robin pointer (pointer favours index not granted last); pulse req_ready for one cycle; latch funct/cond/operands/id into alu_a/alu_b/alu_ctrl and internal regs. Unsupported cmd or failed condition → RESP directly; else → EXEC.
- EXEC: one cycle; at its end capture alu_result into rsp_result, apply FlagW to flags; → RESP.
- RESP: rsp_valid=1, outputs stable; on rsp_ready → IDLE. No grant while in EXEC/RESP.
- Pointer toggles only on a grant.
- Reset values: req_ready 0, alu_a/alu_b 0, alu_ctrl 00, rsp_* 0, flags 0000, pointer → index 0, state IDLE.

## Timing
- Accept at edge T (req_ready high in cycle before T); alu_* valid after T; rsp_valid high after T+1 (latency 2); err/skip responses after T (latency 1).
- Max throughput one op per 3 cycles with rsp_ready tied high.
- Flags visible updated in the same cycle rsp_valid rises; a back-to-back request's condition sees them.
- rsp_ready low stalls in RESP indefinitely; requests wait with valid held.
- Both valid in IDLE: pointer decides; the loser is granted next (no starvation).
- rst_n low in any state: immediate return to reset values; in-flight op discarded, no flag update.
- req_ready is never high while rsp_valid is high.

## Configuration
- CALC_ALU_SCHED_COND_EN defined: req_cond evaluated in IDLE against current flags (EQ,NE,CS,CC,MI,PL,VS,VC,HI,LS,GE,LT,GT,LE,AL; 1111 treated as AL); failure → rsp_skip=1, rsp_result 0, no flag update.
- Not defined: req_cond ignored, every request treated as AL, rsp_skip constant 0.

## Structure
- Package calc_alu_pkg: cmd encodings, ALU control encodings, condition-code constants, NZCV bit indices, FSM state enum.
- Sub-module calc_cond_check: combinational (cond, NZCV) → pass; instantiated only under CALC_ALU_SCHED_COND_EN.

## Test plan
- Req0 ADD S=1, a=0x7FFFFFFF, b=1, rsp_ready=1 → alu_ctrl 00; rsp_valid 2 cycles after accept, rsp_result 0x80000000, rsp_id 0, flags 1001.
- Flags 0011, req1 AND S=1, a=0xF0, b=0x0F → result 0, flags 0111 (C,V kept).
- Both req_valid high continuously, SUB S=0 → grants alternate 0,1,0,1; flags unchanged; rsp_wb 1.
- CMP S=1 a=5 b=5 → rsp_wb 0, flags 0110; cmd 1111 → rsp_err 1 one cycle after accept, flags unchanged.
- rsp_ready low 10 cycles → rsp_valid and rsp_result stable, req_ready 0; release → next grant follows.
- rst_n asserted during EXEC → all outputs reset values immediately; with COND_EN, flags Z=0 and cond EQ → rsp_skip 1.

Source files
------------

// File: rtl/calc_alu_pkg.sv
// Shared encodings for the calculator ALU scheduler: command and ALU-control codes,
// ARM condition codes, NZCV bit positions, FSM states and the command decoder.
package calc_alu_pkg;

  localparam logic [3:0] CmdAnd = 4'b0000;
  localparam logic [3:0] CmdSub = 4'b0010;
  localparam logic [3:0] CmdAdd = 4'b0100;
  localparam logic [3:0] CmdCmp = 4'b1010;
  localparam logic [3:0] CmdOrr = 4'b1100;

  typedef enum logic [1:0] {
    AluAdd = 2'b00,
    AluSub = 2'b01,
    AluAnd = 2'b10,
    AluOrr = 2'b11
  } alu_ctrl_e;

  localparam logic [3:0] CondEq = 4'b0000;
  localparam logic [3:0] CondNe = 4'b0001;
  localparam logic [3:0] CondCs = 4'b0010;
  localparam logic [3:0] CondCc = 4'b0011;
  localparam logic [3:0] CondMi = 4'b0100;
  localparam logic [3:0] CondPl = 4'b0101;
  localparam logic [3:0] CondVs = 4'b0110;
  localparam logic [3:0] CondVc = 4'b0111;
  localparam logic [3:0] CondHi = 4'b1000;
  localparam logic [3:0] CondLs = 4'b1001;
  localparam logic [3:0] CondGe = 4'b1010;
  localparam logic [3:0] CondLt = 4'b1011;
  localparam logic [3:0] CondGt = 4'b1100;
  localparam logic [3:0] CondLe = 4'b1101;
  localparam logic [3:0] CondAl = 4'b1110;
  localparam logic [3:0] CondNv = 4'b1111;

  localparam int unsigned FlagN = 3;
  localparam int unsigned FlagZ = 2;
  localparam int unsigned FlagC = 1;
  localparam int unsigned FlagV = 0;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StExec = 2'b01,
    StResp = 2'b10
  } sched_state_e;

  typedef struct packed {
    logic      ok;     // command is supported
    logic      wb;     // result goes back to a register
    logic      arith;  // flag-setting writes C and V as well as N and Z
    alu_ctrl_e ctrl;
  } cmd_dec_t;

  function automatic cmd_dec_t decode_cmd(logic [3:0] cmd);
    cmd_dec_t d;
    d.ok    = 1'b1;
    d.wb    = 1'b1;
    d.arith = 1'b1;
    d.ctrl  = AluAdd;
    case (cmd)
      CmdAdd: d.ctrl = AluAdd;
      CmdSub: d.ctrl = AluSub;
      CmdCmp: begin
        d.ctrl = AluSub;
        d.wb   = 1'b0;
      end
      CmdAnd: begin
        d.ctrl  = AluAnd;
        d.arith = 1'b0;
      end
      CmdOrr: begin
        d.ctrl  = AluOrr;
        d.arith = 1'b0;
      end
      default: begin
        d.ok = 1'b0;
        d.wb = 1'b0;
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/calc_alu_scheduler_if.sv
// Request, ALU and response signals of the ALU scheduler. The scheduler uses the
// slave modport; requesters, the ALU and the response consumer sit on the master side.
interface calc_alu_scheduler_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic [1:0]            req_valid;
  logic [1:0]            req_ready;
  logic [1:0][4:0]       req_funct;
  logic [1:0][3:0]       req_cond;
  logic [1:0][WIDTH-1:0] req_a;
  logic [1:0][WIDTH-1:0] req_b;

  logic [WIDTH-1:0]      alu_a;
  logic [WIDTH-1:0]      alu_b;
  logic [1:0]            alu_ctrl;
  logic [WIDTH-1:0]      alu_result;
  logic [3:0]            alu_flags;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_id;
  logic [WIDTH-1:0]      rsp_result;
  logic                  rsp_wb;
  logic                  rsp_err;
  logic                  rsp_skip;
  logic [3:0]            flags;

  modport slave (
    input  req_valid, req_funct, req_cond, req_a, req_b,
    input  alu_result, alu_flags, rsp_ready,
    output req_ready, alu_a, alu_b, alu_ctrl,
    output rsp_valid, rsp_id, rsp_result, rsp_wb, rsp_err, rsp_skip, flags
  );

  modport master (
    output req_valid, req_funct, req_cond, req_a, req_b,
    output alu_result, alu_flags, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_ctrl,
    input  rsp_valid, rsp_id, rsp_result, rsp_wb, rsp_err, rsp_skip, flags
  );

endinterface

// File: rtl/calc_cond_check.sv
// ARM condition-code evaluator: decides whether an instruction with the given
// condition executes under the current NZCV flags. 1111 is treated as always.
module calc_cond_check
  import calc_alu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n, z, c, v;

  assign n = nzcv[FlagN];
  assign z = nzcv[FlagZ];
  assign c = nzcv[FlagC];
  assign v = nzcv[FlagV];

  always_comb begin
    pass = 1'b1;
    case (cond)
      CondEq:  pass = z;
      CondNe:  pass = ~z;
      CondCs:  pass = c;
      CondCc:  pass = ~c;
      CondMi:  pass = n;
      CondPl:  pass = ~n;
      CondVs:  pass = v;
      CondVc:  pass = ~v;
      CondHi:  pass = c & ~z;
      CondLs:  pass = ~c | z;
      CondGe:  pass = (n == v);
      CondLt:  pass = (n != v);
      CondGt:  pass = ~z & (n == v);
      CondLe:  pass = z | (n != v);
      CondAl:  pass = 1'b1;
      CondNv:  pass = 1'b1;
      default: pass = 1'b1;
    endcase
  end

endmodule

// File: rtl/calc_alu_scheduler.sv
// Round-robin sharing of the calculator ALU between two requesters, with NZCV ownership.
// Define CALC_ALU_SCHED_COND_EN to evaluate req_cond against the flags before executing.
module calc_alu_scheduler
  import calc_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  calc_alu_scheduler_if.slave  bus
);

  sched_state_e     state_q;
  logic             ptr_q;
  logic [WIDTH-1:0] alu_a_q;
  logic [WIDTH-1:0] alu_b_q;
  logic [1:0]       alu_ctrl_q;
  logic             arith_q;
  logic             set_flags_q;
  logic             rsp_valid_q;
  logic             rsp_id_q;
  logic [WIDTH-1:0] rsp_result_q;
  logic             rsp_wb_q;
  logic             rsp_err_q;
  logic             rsp_skip_q;
  logic [3:0]       flags_q;

  logic [1:0] grant;
  logic       gnt_id;
  logic [4:0] funct_sel;
  cmd_dec_t   dec;
  logic       cond_pass;

  // Grants only from IDLE; on contention the pointer names the favoured requester.
  always_comb begin
    grant = 2'b00;
    if (state_q == StIdle) begin
      case (bus.req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  assign gnt_id    = grant[1];
  assign funct_sel = bus.req_funct[gnt_id];
  assign dec       = decode_cmd(funct_sel[4:1]);

`ifdef CALC_ALU_SCHED_COND_EN
  logic [3:0] cond_sel;

  assign cond_sel = bus.req_cond[gnt_id];

  calc_cond_check u_cond_check (
    .cond (cond_sel),
    .nzcv (flags_q),
    .pass (cond_pass)
  );
`else
  logic unused_cond;

  assign unused_cond = ^bus.req_cond;
  assign cond_pass   = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      ptr_q        <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_ctrl_q   <= AluAdd;
      arith_q      <= 1'b0;
      set_flags_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_wb_q     <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_skip_q   <= 1'b0;
      flags_q      <= 4'b0000;
    end else begin
      case (state_q)
        StIdle: begin
          if (grant != 2'b00) begin
            ptr_q        <= ~gnt_id;
            alu_a_q      <= bus.req_a[gnt_id];
            alu_b_q      <= bus.req_b[gnt_id];
            alu_ctrl_q   <= dec.ctrl;
            arith_q      <= dec.arith;
            set_flags_q  <= funct_sel[0];
            rsp_id_q     <= gnt_id;
            rsp_result_q <= '0;
            rsp_wb_q     <= dec.wb & cond_pass;
            rsp_err_q    <= ~dec.ok;
            rsp_skip_q   <= dec.ok & ~cond_pass;
            // Nothing to execute: answer straight away without touching the ALU or flags.
            if (!dec.ok || !cond_pass) begin
              rsp_valid_q <= 1'b1;
              state_q     <= StResp;
            end else begin
              state_q     <= StExec;
            end
          end
        end
        StExec: begin
          rsp_result_q <= bus.alu_result;
          if (set_flags_q) begin
            if (arith_q) begin
              flags_q <= bus.alu_flags;
            end else begin
              flags_q[FlagN] <= bus.alu_flags[FlagN];
              flags_q[FlagZ] <= bus.alu_flags[FlagZ];
            end
          end
          rsp_valid_q <= 1'b1;
          state_q     <= StResp;
        end
        StResp: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Gated by reset so a requester holding valid never sees an accept during reset.
  assign bus.req_ready  = grant & {2{rst_n}};
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_ctrl   = alu_ctrl_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_wb     = rsp_wb_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.rsp_skip   = rsp_skip_q;
  assign bus.flags      = flags_q;

endmodule

// File: tb/tb_calc_alu_scheduler.sv
// Bench for calc_alu_scheduler: directed cases plus randomized traffic from both requesters,
// checked against a transaction-level model of arbitration, ALU results and NZCV rules.
module tb_calc_alu_scheduler;

  localparam int unsigned WIDTH = 32;

  localparam logic [3:0] OpAdd = 4'b0100;
  localparam logic [3:0] OpSub = 4'b0010;
  localparam logic [3:0] OpCmp = 4'b1010;
  localparam logic [3:0] OpAnd = 4'b0000;
  localparam logic [3:0] OpOrr = 4'b1100;

  typedef struct {
    bit               valid;
    logic [4:0]       funct;
    logic [3:0]       cond;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } req_t;

  typedef struct {
    bit               exec;
    bit               err;
    bit               skip;
    bit               wb;
    logic [WIDTH-1:0] result;
    logic [1:0]       ctrl;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  req_t             pend [2];
  logic [3:0]       m_flags;
  int               m_ptr;
  int               last_grant;
  logic             last_skip;
  logic             last_err;
  logic             last_wb;
  logic [WIDTH-1:0] last_result;

  calc_alu_scheduler_if #(.WIDTH(WIDTH)) bus ();

  calc_alu_scheduler #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural combinational ALU shared by the requesters.
  logic [WIDTH:0] alu_wide;
  logic           alu_v;
  always_comb begin
    alu_wide = '0;
    alu_v    = 1'b0;
    case (bus.alu_ctrl)
      2'b00: begin
        alu_wide = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        alu_v    = (bus.alu_a[WIDTH-1] == bus.alu_b[WIDTH-1]) &&
                   (alu_wide[WIDTH-1] != bus.alu_a[WIDTH-1]);
      end
      2'b01: begin
        alu_wide = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 33'd1;
        alu_v    = (bus.alu_a[WIDTH-1] != bus.alu_b[WIDTH-1]) &&
                   (alu_wide[WIDTH-1] != bus.alu_a[WIDTH-1]);
      end
      2'b10:   alu_wide = {1'b0, bus.alu_a & bus.alu_b};
      default: alu_wide = {1'b0, bus.alu_a | bus.alu_b};
    endcase
    bus.alu_result = alu_wide[WIDTH-1:0];
    bus.alu_flags  = {alu_wide[WIDTH-1], alu_wide[WIDTH-1:0] == '0, alu_wide[WIDTH], alu_v};
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

`ifdef CALC_ALU_SCHED_COND_EN
  function automatic bit cond_holds(input logic [3:0] cond, input logic [3:0] fl);
    bit n, z, c, v, ok;
    {n, z, c, v} = fl;
    case (cond)
      4'd0:    ok = z;
      4'd1:    ok = !z;
      4'd2:    ok = c;
      4'd3:    ok = !c;
      4'd4:    ok = n;
      4'd5:    ok = !n;
      4'd6:    ok = v;
      4'd7:    ok = !v;
      4'd8:    ok = c && !z;
      4'd9:    ok = !c || z;
      4'd10:   ok = (n == v);
      4'd11:   ok = (n != v);
      4'd12:   ok = !z && (n == v);
      4'd13:   ok = z || (n != v);
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction
`endif

  // Reference: what the request should produce and what the flags become afterwards.
  task automatic ref_op(input req_t r, input logic [3:0] fl_in, output exp_t e,
                        output logic [3:0] fl_out);
    longint unsigned  ua, ub;
    longint           sa, sb, strue;
    logic [WIDTH-1:0] res;
    bit               c, v, arith, known, pass;
    ua = r.a;  ub = r.b;
    sa = $signed(r.a);  sb = $signed(r.b);
    e.exec = 0;  e.err = 0;  e.skip = 0;  e.wb = 0;  e.result = '0;  e.ctrl = 2'b00;
    fl_out = fl_in;
    c = 0;  v = 0;  arith = 1;  known = 1;  res = '0;  strue = 0;
    case (r.funct[4:1])
      OpAdd: begin
        res = r.a + r.b;  strue = sa + sb;
        c = (ua + ub) >= 64'h1_0000_0000;  e.ctrl = 2'b00;
      end
      OpSub, OpCmp: begin
        res = r.a - r.b;  strue = sa - sb;
        c = (ua >= ub);  e.ctrl = 2'b01;
      end
      OpAnd: begin res = r.a & r.b;  arith = 0;  e.ctrl = 2'b10; end
      OpOrr: begin res = r.a | r.b;  arith = 0;  e.ctrl = 2'b11; end
      default: known = 0;
    endcase
    v = arith && (strue != longint'($signed(res)));
`ifdef CALC_ALU_SCHED_COND_EN
    pass = cond_holds(r.cond, fl_in);
`else
    pass = 1'b1;
`endif
    if (!known) e.err = 1;
    else if (!pass) e.skip = 1;
    else begin
      e.exec   = 1;
      e.result = res;
      e.wb     = (r.funct[4:1] != OpCmp);
      if (r.funct[0]) begin
        if (arith) fl_out = {res[WIDTH-1], res == '0, c, v};
        else       fl_out = {res[WIDTH-1], res == '0, fl_in[1:0]};
      end
    end
  endtask

  function automatic req_t mk_req(input logic [3:0] cmd, input bit s, input logic [3:0] cond,
                                  input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_t r;
    r.valid = 1'b1;  r.funct = {cmd, s};  r.cond = cond;  r.a = a;  r.b = b;
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      4:       return WIDTH'($urandom_range(0, 7));
      default: return $urandom;
    endcase
  endfunction

  function automatic req_t rand_req();
    logic [3:0] cmd;
    case ($urandom_range(0, 5))
      0:       cmd = OpAdd;
      1:       cmd = OpSub;
      2:       cmd = OpCmp;
      3:       cmd = OpAnd;
      4:       cmd = OpOrr;
      default: cmd = 4'($urandom);
    endcase
    return mk_req(cmd, 1'($urandom), 4'($urandom), rand_operand(), rand_operand());
  endfunction

  task automatic drive_reqs();
    for (int i = 0; i < 2; i++) begin
      bus.req_valid[i] = pend[i].valid;
      bus.req_funct[i] = pend[i].funct;
      bus.req_cond[i]  = pend[i].cond;
      bus.req_a[i]     = pend[i].a;
      bus.req_b[i]     = pend[i].b;
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_req_ready"}, bus.req_ready, 2'b00);
    check({tag, "_alu_a"}, bus.alu_a, 0);
    check({tag, "_alu_b"}, bus.alu_b, 0);
    check({tag, "_alu_ctrl"}, bus.alu_ctrl, 0);
    check({tag, "_rsp_bits"}, {bus.rsp_valid, bus.rsp_id, bus.rsp_wb, bus.rsp_err, bus.rsp_skip}, 0);
    check({tag, "_rsp_result"}, bus.rsp_result, 0);
    check({tag, "_flags"}, bus.flags, 0);
  endtask

  // One request from IDLE through its response; entered and left #1 after a rising edge.
  task automatic txn(input int stall);
    int         g, lat;
    exp_t       e;
    logic [3:0] fl_next;
    logic [1:0] exp_gnt;
    drive_reqs();
    if (pend[0].valid && pend[1].valid) g = m_ptr;
    else if (pend[1].valid)             g = 1;
    else                                g = 0;
    exp_gnt = (g == 1) ? 2'b10 : 2'b01;
    bus.rsp_ready = (stall == 0);
    ref_op(pend[g], m_flags, e, fl_next);
    @(negedge clk);
    check("req_ready", bus.req_ready, exp_gnt);
    @(posedge clk);
    #1;
    pend[g].valid = 1'b0;
    drive_reqs();
    m_ptr = 1 - g;  m_flags = fl_next;  last_grant = g;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1 && e.exec) begin
        check("alu_ctrl", bus.alu_ctrl, e.ctrl);
        check("alu_a", bus.alu_a, pend[g].a);
        check("alu_b", bus.alu_b, pend[g].b);
      end
      if (!bus.rsp_valid) check("busy_ready", bus.req_ready, 2'b00);
    end while (!bus.rsp_valid && lat < 6);
    check("latency", lat, e.exec ? 2 : 1);
    check("rsp_id", bus.rsp_id, g);
    check("rsp_err", bus.rsp_err, e.err);
    check("rsp_skip", bus.rsp_skip, e.skip);
    check("flags", bus.flags, m_flags);
    check("rsp_ready_excl", bus.req_ready, 2'b00);
    if (e.exec || e.skip) check("rsp_result", bus.rsp_result, e.result);
    if (e.exec) check("rsp_wb", bus.rsp_wb, e.wb);
    last_skip = bus.rsp_skip;  last_err = bus.rsp_err;
    last_wb = bus.rsp_wb;  last_result = bus.rsp_result;
    if (stall > 0) begin
      repeat (stall) begin
        @(negedge clk);
        check("stall_valid", bus.rsp_valid, 1'b1);
        check("stall_ready", bus.req_ready, 2'b00);
        if (e.exec || e.skip) check("stall_result", bus.rsp_result, e.result);
      end
      bus.rsp_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    m_flags = 4'b0000;  m_ptr = 0;  last_grant = 0;
    bus.rsp_ready = 1'b0;
    pend[0] = mk_req(OpAdd, 1'b1, 4'hE, 32'd3, 32'd4);
    pend[1] = mk_req(OpSub, 1'b1, 4'hE, 32'd9, 32'd2);
    drive_reqs();
    repeat (3) @(negedge clk);
    check_reset("rst");
    pend[0].valid = 1'b0;  pend[1].valid = 1'b0;
    drive_reqs();
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    pend[0] = mk_req(OpAdd, 1'b1, 4'hE, 32'h7FFF_FFFF, 32'h1);
    txn(0);
    check("tp_add_result", last_result, 32'h8000_0000);
    check("tp_add_flags", bus.flags, 4'b1001);

    pend[1] = mk_req(OpSub, 1'b1, 4'hE, 32'h8000_0000, 32'h1);
    txn(0);
    check("tp_sub_flags", bus.flags, 4'b0011);
    pend[1] = mk_req(OpAnd, 1'b1, 4'hE, 32'hF0, 32'h0F);
    txn(1);
    check("tp_and_result", last_result, 32'h0);
    check("tp_and_flags", bus.flags, 4'b0111);

    pend[0] = mk_req(OpCmp, 1'b1, 4'hE, 32'd5, 32'd5);
    txn(0);
    check("tp_cmp_wb", last_wb, 1'b0);
    check("tp_cmp_flags", bus.flags, 4'b0110);
    pend[1] = mk_req(4'hF, 1'b1, 4'hE, 32'd1, 32'd2);
    txn(0);
    check("tp_err", last_err, 1'b1);
    check("tp_err_flags", bus.flags, 4'b0110);

    // Long response stall with the other requester waiting, then it gets the next grant.
    pend[0] = mk_req(OpOrr, 1'b0, 4'hE, 32'h1234, 32'h4321);
    pend[1] = mk_req(OpAdd, 1'b0, 4'hE, 32'd10, 32'd20);
    txn(10);
    check("tp_stall_grant", last_grant, 0);
    txn(0);
    check("tp_after_stall_grant", last_grant, 1);

    // Reset while the operation is in EXEC.
    pend[0] = mk_req(OpAdd, 1'b1, 4'hE, 32'h1, 32'h1);
    drive_reqs();
    @(negedge clk);
    check("exec_rst_grant", bus.req_ready, 2'b01);
    @(posedge clk);
    #1;
    pend[0].valid = 1'b0;
    drive_reqs();
    #2 rst_n = 1'b0;
    #1 check_reset("rst_exec");
    m_flags = 4'b0000;  m_ptr = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    pend[0] = mk_req(OpSub, 1'b0, 4'hE, $urandom, $urandom);
    pend[1] = mk_req(OpSub, 1'b0, 4'hE, $urandom, $urandom);
    for (int k = 0; k < 4; k++) begin
      txn(0);
      check("alt_grant", last_grant, k % 2);
      if (k < 2) pend[last_grant] = mk_req(OpSub, 1'b0, 4'hE, $urandom, $urandom);
    end
    check("alt_flags", bus.flags, 4'b0000);

`ifdef CALC_ALU_SCHED_COND_EN
    pend[0] = mk_req(OpAdd, 1'b1, 4'h0, 32'd7, 32'd8);
    txn(0);
    check("tp_cond_skip", last_skip, 1'b1);
    check("tp_cond_flags", bus.flags, 4'b0000);
`endif

    for (int it = 0; it < 300; it++) begin
      int stall;
      for (int i = 0; i < 2; i++) begin
        if (!pend[i].valid && ($urandom_range(0, 1) == 1)) pend[i] = rand_req();
      end
      if (!pend[0].valid && !pend[1].valid) pend[$urandom_range(0, 1)] = rand_req();
      stall = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0;
      txn(stall);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
